// File: rtl/mod_exp_ctrl.sv
// mod_exp_ctrl: left-to-right square-and-multiply sequencer that
// drives an external interleaved modular multiplier.
module mod_exp_ctrl #(
  parameter int NBITS = 4,
  parameter int EBITS = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start_p,
  input  logic [NBITS-1:0]         base,
  input  logic [EBITS-1:0]         exp,
  input  logic [NBITS-1:0]         m,
  input  logic [$clog2(NBITS)-1:0] m_msb,
  output logic                     busy,
  output logic [NBITS-1:0]         result,
  output logic                     done_irq_p,
  output logic                     mul_enable_p,
  output logic [NBITS-1:0]         mul_a,
  output logic [NBITS-1:0]         mul_b,
  output logic [NBITS-1:0]         mul_m,
  output logic [$clog2(NBITS)-1:0] mul_m_msb,
  input  logic [NBITS-1:0]         mul_y,
  input  logic                     mul_done_irq_p
);

  localparam int MW = $clog2(NBITS);
  localparam int BW = $clog2(EBITS) + 1;

  typedef enum logic [2:0] {
    IDLE,
    SCAN,
    NEXT,
    SQR_REQ,
    SQR_WAIT,
    MUL_REQ,
    MUL_WAIT,
    DONE
  } state_t;

  state_t state, state_nxt;

  logic [NBITS-1:0] base_r, base_nxt;
  logic [NBITS-1:0] m_r, m_nxt;
  logic [MW-1:0]    m_msb_r, m_msb_nxt;
  logic [EBITS-1:0] exp_sh, exp_nxt;
  logic [BW-1:0]    bits_left, bits_nxt;
  logic [NBITS-1:0] acc, acc_nxt;
  logic [NBITS-1:0] a_r, a_nxt;
  logic [NBITS-1:0] b_r, b_nxt;
  logic [NBITS-1:0] res_r, res_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      base_r    <= '0;
      m_r       <= '0;
      m_msb_r   <= '0;
      exp_sh    <= '0;
      bits_left <= '0;
      acc       <= '0;
      a_r       <= '0;
      b_r       <= '0;
      res_r     <= '0;
    end else begin
      state     <= state_nxt;
      base_r    <= base_nxt;
      m_r       <= m_nxt;
      m_msb_r   <= m_msb_nxt;
      exp_sh    <= exp_nxt;
      bits_left <= bits_nxt;
      acc       <= acc_nxt;
      a_r       <= a_nxt;
      b_r       <= b_nxt;
      res_r     <= res_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    base_nxt  = base_r;
    m_nxt     = m_r;
    m_msb_nxt = m_msb_r;
    exp_nxt   = exp_sh;
    bits_nxt  = bits_left;
    acc_nxt   = acc;
    a_nxt     = a_r;
    b_nxt     = b_r;
    res_nxt   = res_r;
    unique case (state)
      IDLE: begin
        if (start_p) begin
          base_nxt  = base;
          m_nxt     = m;
          m_msb_nxt = m_msb;
          exp_nxt   = exp;
          bits_nxt  = BW'(EBITS);
          state_nxt = SCAN;
        end
      end
      SCAN: begin
        exp_nxt  = exp_sh << 1;
        bits_nxt = bits_left - BW'(1);
        if (exp_sh[EBITS-1]) begin
          acc_nxt   = base_r;
          state_nxt = NEXT;
        end else if (bits_left == BW'(1)) begin
          // exp == 0: x^0 is 1, which reduces to 0 only when m == 1
          acc_nxt   = (m_r == NBITS'(1)) ? '0 : NBITS'(1);
          state_nxt = DONE;
        end
      end
      NEXT: begin
        if (bits_left == '0) begin
          state_nxt = DONE;
        end else begin
          a_nxt     = acc;
          b_nxt     = acc;
          state_nxt = SQR_REQ;
        end
      end
      SQR_REQ: state_nxt = SQR_WAIT;
      SQR_WAIT: begin
        if (mul_done_irq_p) begin
          acc_nxt = mul_y;
          if (exp_sh[EBITS-1]) begin
            a_nxt     = mul_y;
            b_nxt     = base_r;
            state_nxt = MUL_REQ;
          end else begin
            exp_nxt   = exp_sh << 1;
            bits_nxt  = bits_left - BW'(1);
            state_nxt = NEXT;
          end
        end
      end
      MUL_REQ: state_nxt = MUL_WAIT;
      MUL_WAIT: begin
        if (mul_done_irq_p) begin
          acc_nxt   = mul_y;
          exp_nxt   = exp_sh << 1;
          bits_nxt  = bits_left - BW'(1);
          state_nxt = NEXT;
        end
      end
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    // result is loaded on entry so it is valid during the done pulse
    if (state_nxt == DONE && state != DONE) begin
      res_nxt = acc_nxt;
    end
  end

  assign busy         = (state != IDLE) && (state != DONE);
  assign done_irq_p   = (state == DONE);
  assign mul_enable_p = (state == SQR_REQ) || (state == MUL_REQ);
  assign result       = res_r;
  assign mul_a        = a_r;
  assign mul_b        = b_r;
  assign mul_m        = m_r;
  assign mul_m_msb    = m_msb_r;

endmodule
